fetch_pc_queue: RTL and testbench
=================================

// Module: fetch_pc_queue
// PURPOSE
//   Fetch front end feeding the instruction cache's two combinational read ports.
//   Holds the fetch PC and drives word addresses for PC and PC+4 each cycle.
//   Captures the two returned instructions in the same cycle into an instruction queue.
//   Presents queued {pc, inst} pairs to decode with a valid/ready handshake; branch redirect flushes the queue.
// PARAMETERS
//   DEPTH     8      queue entries; power of 2, >= 4
//   PC_W      64     PC / address width
//   INST_W    32     instruction width
//   RESET_PC  64'h0  fetch PC after reset; bits [1:0] must be 0
// PORTS
//   clk             in   1              clock, rising edge
//   rst_n           in   1              asynchronous active-low reset
//   redirect_valid  in   1              flush queue and restart fetch at redirect_pc
//   redirect_pc     in   PC_W           new fetch PC; bits [1:0] ignored (treated as 0)
//   ic_addr0        out  PC_W           icache word address for PC   = {2'b0, pc[63:2]}
//   ic_addr1        out  PC_W           icache word address for PC+4 = {2'b0, (pc+4)[63:2]}
//   ic_inst0        in   INST_W         instruction at ic_addr0, valid in the same cycle
//   ic_inst1        in   INST_W         instruction at ic_addr1, valid in the same cycle
//   deq_valid       out  1              head entry available
//   deq_ready       in   1              decode accepts head entry
//   deq_pc          out  PC_W           byte PC of head entry
//   deq_inst        out  INST_W         instruction of head entry
//   count           out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//   - Reset (async, rst_n=0): pc=RESET_PC, head=tail=0, count=0, deq_valid=0, deq_pc=0, deq_inst=0.
//   - ic_addr0/1 are combinational from the pc register only; never from inputs.
//   - The head of the queue is registered storage.
//     - deq_pc/deq_inst show the head entry when deq_valid=1, and 0 otherwise.
//   - Per-cycle mode, evaluated in priority order:
//     - FLUSH: redirect_valid=1.
//       - Next: pc=redirect_pc&~3, head=tail=0, count=0; no enqueue.
//       - deq_valid is forced 0 this cycle (combinational), so no pop occurs.
//     - FILL: redirect_valid=0 and (DEPTH - count) >= 2, where count is the start-of-cycle value.
//       - Enqueue {pc, ic_inst0} at tail, then {pc+4, ic_inst1} at tail+1; pc += 8.
//     - HOLD: redirect_valid=0 and (DEPTH - count) < 2.
//       - No enqueue, pc unchanged; there are no partial single-instruction fetches.
//   - Pop: deq_valid && deq_ready advances head by 1.
//     - FILL + pop in one cycle: count += 1. FILL only: count += 2. Pop only: count -= 1.
//   - Free space uses start-of-cycle count (same-cycle pop not credited): a queue at DEPTH-1 does not fetch even if popping.
//   - deq_valid = (count != 0) && !redirect_valid.
//   - head, tail and storage index wrap modulo DEPTH.
//   - pc arithmetic wraps modulo 2^PC_W; e.g. pc=...FFFC gives pc+4=0 and ic_addr1=0.
//   - count never exceeds DEPTH; overflow is structurally impossible.
//   - No bypass: an instruction enqueued in cycle N is dequeuable at the earliest in cycle N+1.
// TESTING
//   1 Reset, RESET_PC=0, deq_ready=0 -> ic_addr0=0,2,4,6 on successive cycles.
//     count=2,4,6,8, then HOLD with ic_addr0=8 and count=8 stable.
//   2 From full, deq_ready=1, icache model inst=addr^0xA5A5A5A5.
//     -> pops in order pc 0x0,0x4,0x8,...; deq_inst matches the model.
//     -> fetch resumes only once start-of-cycle count<=6; no gaps in the pc sequence.
//   3 count=5, redirect_valid=1 with pc 0x1004 -> deq_valid=0 in that cycle.
//     Next cycle: count=0, ic_addr0=0x401; the cycle after: count=2, head pc=0x1004, then 0x1008.
//   4 redirect_pc=0x1006 -> behaves exactly as 0x1004; ic_addr0=0x401.
//   5 redirect_pc=64'hFFFF_FFFF_FFFF_FFFC -> ic_addr1=0; enqueued pcs are ...FFFC then 0x0; next pc=0x4.
//   6 rst_n dropped mid-cycle with count=6 -> immediately (no clock) deq_valid=0, count=0, ic_addr0=RESET_PC>>2.
//     Fetch restarts from RESET_PC after release.

Source files
------------

// File: rtl/fetch_pc_queue.sv
// Fetch front end: drives two icache word addresses (PC, PC+4) each cycle, queues the
// returned {pc, inst} pairs and presents them to decode with a valid/ready handshake.
module fetch_pc_queue #(
    parameter int unsigned     DEPTH    = 8,
    parameter int unsigned     PC_W     = 64,
    parameter int unsigned     INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic [PC_W-1:0]            ic_addr0,
    output logic [PC_W-1:0]            ic_addr1,
    input  logic [INST_W-1:0]          ic_inst0,
    input  logic [INST_W-1:0]          ic_inst1,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [PC_W-1:0]            deq_pc,
    output logic [INST_W-1:0]          deq_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ModeFlush,
        ModeFill,
        ModeHold
    } mode_e;

    logic [PC_W-1:0]   pc_q, pc_d, pc_plus4;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, tail_next;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    mode_e             mode;
    logic              pop;

    // Address wrap modulo 2^PC_W falls out of the fixed-width add.
    assign pc_plus4  = pc_q + PC_W'(4);
    assign ic_addr0  = {2'b00, pc_q[PC_W-1:2]};
    assign ic_addr1  = {2'b00, pc_plus4[PC_W-1:2]};
    assign tail_next = tail_q + PTR_W'(1);

    assign deq_valid = (count_q != '0) && !redirect_valid;
    assign pop       = deq_valid && deq_ready;
    assign deq_pc    = deq_valid ? pc_mem[head_q] : '0;
    assign deq_inst  = deq_valid ? inst_mem[head_q] : '0;
    assign count     = count_q;

    // Free space is judged on the start-of-cycle count; a same-cycle pop is not credited.
    always_comb begin
        mode = ModeHold;
        if (redirect_valid) begin
            mode = ModeFlush;
        end else if (count_q <= CNT_W'(DEPTH - 2)) begin
            mode = ModeFill;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case (mode)
            ModeFlush: begin
                pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
            ModeFill: begin
                pc_d    = pc_q + PC_W'(8);
                tail_d  = tail_q + PTR_W'(2);
                head_d  = head_q + PTR_W'(pop);
                count_d = count_q + (pop ? CNT_W'(1) : CNT_W'(2));
            end
            ModeHold: begin
                head_d  = head_q + PTR_W'(pop);
                count_d = count_q - CNT_W'(pop);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: it is only visible while deq_valid is high.
    always_ff @(posedge clk) begin
        if (mode == ModeFill) begin
            pc_mem[tail_q]      <= pc_q;
            inst_mem[tail_q]    <= ic_inst0;
            pc_mem[tail_next]   <= pc_plus4;
            inst_mem[tail_next] <= ic_inst1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue with a combinational icache model
// returning inst = word_addr ^ 32'hA5A5A5A5.
module tb_fetch_pc_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] ic_addr0, ic_addr1;
    logic [31:0] ic_inst0, ic_inst1;
    logic        deq_valid, deq_ready;
    logic [63:0] deq_pc;
    logic [31:0] deq_inst;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_pc_queue #(
        .DEPTH    (8),
        .PC_W     (64),
        .INST_W   (32),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_addr0       (ic_addr0),
        .ic_addr1       (ic_addr1),
        .ic_inst0       (ic_inst0),
        .ic_inst1       (ic_inst1),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_inst       (deq_inst),
        .count          (count)
    );

    always #5 clk = ~clk;

    assign ic_inst0 = ic_addr0[31:0] ^ 32'hA5A5A5A5;
    assign ic_inst1 = ic_addr1[31:0] ^ 32'hA5A5A5A5;

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[33:2] ^ 32'hA5A5A5A5;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drain-from-full expectations, observed before each edge.
    logic [3:0]  t2_count [6] = '{4'd8, 4'd7, 4'd6, 4'd7, 4'd6, 4'd7};
    logic [63:0] t2_pc    [6] = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h14};
    logic [63:0] t2_addr  [6] = '{64'h8, 64'h8, 64'h8, 64'hA, 64'hA, 64'hC};

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;
        #12 rst_n = 1'b1;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_deq_pc", deq_pc, 64'd0);
        check("rst_deq_inst", 64'(deq_inst), 64'd0);
        check("rst_addr0", ic_addr0, 64'd0);
        check("rst_addr1", ic_addr1, 64'd1);

        // 1: fill to full, then hold
        for (int i = 1; i <= 4; i++) begin
            step();
            check("fill_count", 64'(count), 64'(2 * i));
            check("fill_addr0", ic_addr0, 64'(2 * i));
            if (i == 1) begin
                check("fill_head_pc", deq_pc, 64'h0);
                check("fill_head_inst", 64'(deq_inst), 64'hA5A5A5A5);
            end
        end
        step();
        step();
        check("hold_count", 64'(count), 64'd8);
        check("hold_addr0", ic_addr0, 64'd8);

        // 2: drain with ready; fetch resumes only at start-of-cycle count <= 6
        deq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("drain_count", 64'(count), 64'(t2_count[i]));
            check("drain_pc", deq_pc, t2_pc[i]);
            check("drain_inst", 64'(deq_inst), 64'(inst_of(t2_pc[i])));
            check("drain_addr0", ic_addr0, t2_addr[i]);
            step();
        end
        for (int k = 6; k < 16; k++) begin
            check("seq_valid", 64'(deq_valid), 64'd1);
            check("seq_pc", deq_pc, 64'(4 * k));
            check("seq_inst", 64'(deq_inst), 64'(inst_of(64'(4 * k))));
            step();
        end

        // 3: reach count=5, then redirect to 0x1004
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        #1;
        check("flush_deq_valid", 64'(deq_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("flush_count", 64'(count), 64'd0);
        check("flush_addr0", ic_addr0, 64'h800);
        step();
        step();
        step();
        step();
        check("pre_redir_count", 64'(count), 64'd5);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1004;
        #1;
        check("redir_deq_valid", 64'(deq_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        deq_ready      = 1'b0;
        #1;
        check("redir_count", 64'(count), 64'd0);
        check("redir_addr0", ic_addr0, 64'h401);
        check("redir_valid0", 64'(deq_valid), 64'd0);
        step();
        check("redir_count2", 64'(count), 64'd2);
        check("redir_head", deq_pc, 64'h1004);
        check("redir_inst", 64'(deq_inst), 64'(inst_of(64'h1004)));
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check("redir_head2", deq_pc, 64'h1008);
        check("redir_count3", 64'(count), 64'd3);

        // 4: unaligned redirect behaves as aligned
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1006;
        step();
        redirect_valid = 1'b0;
        #1;
        check("unal_addr0", ic_addr0, 64'h401);
        check("unal_addr1", ic_addr1, 64'h402);
        step();
        check("unal_head", deq_pc, 64'h1004);
        check("unal_count", 64'(count), 64'd2);

        // 5: pc wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        #1;
        check("wrap_addr0", ic_addr0, 64'h3FFF_FFFF_FFFF_FFFF);
        check("wrap_addr1", ic_addr1, 64'h0);
        step();
        check("wrap_head", deq_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_inst", 64'(deq_inst), 64'h5A5A5A5A);
        check("wrap_next_addr0", ic_addr0, 64'h1);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check("wrap_head2", deq_pc, 64'h0);
        check("wrap_inst2", 64'(deq_inst), 64'hA5A5A5A5);
        check("wrap_count", 64'(count), 64'd3);

        // 6: asynchronous reset mid-cycle with count=6
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        step();
        check("arst_pre_count", 64'(count), 64'd6);
        #3 rst_n = 1'b0;
        #1;
        check("arst_deq_valid", 64'(deq_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_addr0", ic_addr0, 64'd0);
        #2 rst_n = 1'b1;
        step();
        check("arst_restart_count", 64'(count), 64'd2);
        check("arst_restart_head", deq_pc, 64'h0);
        check("arst_restart_addr0", ic_addr0, 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
